// File: rtl/mtr_drv_ctrl.sv
// One PWM11 motor-drive channel: speed-to-duty conversion, period-aligned
// duty commits, enable/fault sequencing and over-current trip counting.
module mtr_drv_ctrl #(
    parameter logic [10:0] DUTY_OFF  = 11'd128,
    parameter int unsigned OVR_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] spd_cmd,
    input  logic        clr_fault,
    input  logic        pwm_synch,
    input  logic        ovr_i_blank_n,
    input  logic        ovr_i,
    output logic [10:0] duty,
    output logic        fwd,
    output logic        drv_en,
    output logic        fault
);

    localparam logic [7:0] LIM = 8'(OVR_LIMIT);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t      state;
    logic        ovr_seen;
    logic [7:0]  ovr_cnt;
    logic [7:0]  cnt_inc;
    logic [11:0] neg;
    logic [11:0] mag;
    logic [12:0] sum;
    logic [10:0] duty_calc;
    logic        fwd_calc;
    logic        ovr_vld;
    logic        hit;
    logic        trip;

    always_comb begin
        neg = 12'd0 - spd_cmd;
        if (!spd_cmd[11])
            mag = spd_cmd;
        else if (neg[11])
            mag = 12'h7FF;
        else
            mag = neg;
        sum       = {1'b0, mag} + {2'b00, DUTY_OFF};
        duty_calc = '0;
        if (mag != 12'd0)
            duty_calc = (sum > 13'd2047) ? 11'h7FF : sum[10:0];
        // zero command keeps the last direction
        fwd_calc = (mag == 12'd0) ? fwd : ~spd_cmd[11];
    end

    assign ovr_vld = ovr_i & ovr_i_blank_n;
    assign hit     = ovr_seen | ovr_vld;
    assign cnt_inc = (ovr_cnt >= LIM) ? ovr_cnt : ovr_cnt + 8'd1;
    assign trip    = pwm_synch & hit & (ovr_cnt == LIM - 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            duty     <= '0;
            fwd      <= 1'b1;
            drv_en   <= 1'b0;
            fault    <= 1'b0;
            ovr_seen <= 1'b0;
            ovr_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    duty   <= '0;
                    drv_en <= 1'b0;
                    if (pwm_synch && en) begin
                        state  <= RUN;
                        duty   <= duty_calc;
                        fwd    <= fwd_calc;
                        drv_en <= 1'b1;
                    end
                end
                RUN: begin
                    if (pwm_synch) begin
                        ovr_seen <= 1'b0;
                        ovr_cnt  <= hit ? cnt_inc : 8'd0;
                    end else if (ovr_vld) begin
                        ovr_seen <= 1'b1;
                    end
                    // trip beats disable, disable beats duty update
                    if (trip) begin
                        state  <= FAULT;
                        fault  <= 1'b1;
                        duty   <= '0;
                        drv_en <= 1'b0;
                    end else if (!en) begin
                        state  <= IDLE;
                        duty   <= '0;
                        drv_en <= 1'b0;
                    end else if (pwm_synch) begin
                        duty <= duty_calc;
                        fwd  <= fwd_calc;
                    end
                end
                FAULT: begin
                    if (clr_fault && !en) begin
                        state    <= IDLE;
                        fault    <= 1'b0;
                        ovr_cnt  <= '0;
                        ovr_seen <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtr_drv_ctrl.sv
// Directed self-checking bench for mtr_drv_ctrl using a 16-cycle
// emulated PWM period (blank_n high in cycles 4..11, synch in cycle 15).
module tb_mtr_drv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] spd_cmd;
    logic        clr_fault;
    logic        pwm_synch;
    logic        ovr_i_blank_n;
    logic        ovr_i;
    logic [10:0] duty;
    logic        fwd;
    logic        drv_en;
    logic        fault;

    int total  = 0;
    int passed = 0;

    mtr_drv_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .spd_cmd       (spd_cmd),
        .clr_fault     (clr_fault),
        .pwm_synch     (pwm_synch),
        .ovr_i_blank_n (ovr_i_blank_n),
        .ovr_i         (ovr_i),
        .duty          (duty),
        .fwd           (fwd),
        .drv_en        (drv_en),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic step(input bit s, input bit bn, input bit oi);
        pwm_synch     = s;
        ovr_i_blank_n = bn;
        ovr_i         = oi;
        @(posedge clk);
        #1;
        pwm_synch     = 1'b0;
        ovr_i_blank_n = 1'b0;
        ovr_i         = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic period(input bit hit_win, input bit hit_blank);
        for (int c = 0; c < 16; c++)
            step(c == 15, (c >= 4) && (c < 12),
                 (hit_win && c == 6) || (hit_blank && c == 1));
    endtask

    task automatic chk_out(input string name, input logic [10:0] e_duty,
                           input logic e_fwd, input logic e_drv,
                           input logic e_fault);
        total++;
        if (duty !== e_duty || fwd !== e_fwd || drv_en !== e_drv ||
            fault !== e_fault)
            $display("FAIL %s: got duty=%0d fwd=%b drv_en=%b fault=%b, want duty=%0d fwd=%b drv_en=%b fault=%b",
                     name, duty, fwd, drv_en, fault,
                     e_duty, e_fwd, e_drv, e_fault);
        else
            passed++;
    endtask

    task automatic test_reset;
        total++;
        if (duty !== 11'd0 || fwd !== 1'b1 || drv_en !== 1'b0 || fault !== 1'b0)
            $display("FAIL reset_init: got duty=%0d fwd=%b drv_en=%b fault=%b, want 0 1 0 0",
                     duty, fwd, drv_en, fault);
        else
            passed++;
        en      = 1'b1;
        spd_cmd = -12'sd640;
        steps(3);
        step(1'b1, 1'b0, 1'b0);
        chk_out("reset_prerun", 11'h300, 1'b0, 1'b1, 1'b0);
        steps(2);
        #2 rst = 1'b1;
        #1;
        total++;
        if (duty !== 11'd0 || fwd !== 1'b1 || drv_en !== 1'b0 || fault !== 1'b0)
            $display("FAIL reset_async: got duty=%0d fwd=%b drv_en=%b fault=%b, want 0 1 0 0",
                     duty, fwd, drv_en, fault);
        else
            passed++;
        #1 rst = 1'b0;
        en = 1'b0;
        @(posedge clk);
        #1;
        chk_out("reset_idle", 11'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_run;
        en      = 1'b1;
        spd_cmd = 12'sd500;
        steps(15);
        chk_out("run_wait_synch", 11'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_out("run_first", 11'd628, 1'b1, 1'b1, 1'b0);
        steps(5);
        spd_cmd = -12'sd300;
        steps(5);
        chk_out("run_midperiod", 11'd628, 1'b1, 1'b1, 1'b0);
        steps(5);
        step(1'b1, 1'b0, 1'b0);
        chk_out("run_reverse", 11'd428, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_saturation;
        spd_cmd = 12'sd1950;
        period(1'b0, 1'b0);
        chk_out("sat_pos", 11'd2047, 1'b1, 1'b1, 1'b0);
        spd_cmd = 12'h800;
        period(1'b0, 1'b0);
        chk_out("sat_neg2048", 11'd2047, 1'b0, 1'b1, 1'b0);
        spd_cmd = 12'd0;
        period(1'b0, 1'b0);
        chk_out("zero_holds_dir", 11'd0, 1'b0, 1'b1, 1'b0);
        spd_cmd = 12'd1;
        period(1'b0, 1'b0);
        chk_out("plus_one", 11'd129, 1'b1, 1'b1, 1'b0);
        spd_cmd = -12'sd1;
        period(1'b0, 1'b0);
        chk_out("minus_one", 11'd129, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_blanking;
        spd_cmd = 12'sd200;
        for (int p = 0; p < 20; p++) period(1'b0, 1'b1);
        total++;
        if (dut.ovr_cnt !== 8'd0)
            $display("FAIL blank_cnt: got ovr_cnt=%0d, want 0", dut.ovr_cnt);
        else
            passed++;
        chk_out("blank_nofault", 11'd328, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_overcurrent;
        for (int p = 0; p < 7; p++) period(1'b1, 1'b0);
        total++;
        if (dut.ovr_cnt !== 8'd7)
            $display("FAIL oc_cnt7: got ovr_cnt=%0d, want 7", dut.ovr_cnt);
        else
            passed++;
        period(1'b0, 1'b0);
        total++;
        if (dut.ovr_cnt !== 8'd0)
            $display("FAIL oc_clean: got ovr_cnt=%0d, want 0", dut.ovr_cnt);
        else
            passed++;
        for (int p = 0; p < 7; p++) period(1'b1, 1'b0);
        chk_out("oc_7_no_trip", 11'd328, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 15; c++)
            step(1'b0, (c >= 4) && (c < 12), c == 6);
        chk_out("oc_before_8th", 11'd328, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_out("oc_trip", 11'd0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_fault_clear;
        clr_fault = 1'b1;
        steps(3);
        chk_out("clr_with_en", 11'd0, 1'b1, 1'b0, 1'b1);
        clr_fault = 1'b0;
        en = 1'b0;
        steps(2);
        chk_out("fault_held", 11'd0, 1'b1, 1'b0, 1'b1);
        clr_fault = 1'b1;
        steps(1);
        clr_fault = 1'b0;
        chk_out("fault_cleared", 11'd0, 1'b1, 1'b0, 1'b0);
        total++;
        if (dut.ovr_cnt !== 8'd0)
            $display("FAIL clr_cnt: got ovr_cnt=%0d, want 0", dut.ovr_cnt);
        else
            passed++;
        en = 1'b1;
        spd_cmd = 12'sd100;
        steps(5);
        chk_out("reen_wait", 11'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_out("reen_run", 11'd228, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_disable;
        spd_cmd = 12'sd300;
        steps(3);
        en = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk_out("dis_over_synch", 11'd0, 1'b1, 1'b0, 1'b0);
        en = 1'b1;
        steps(4);
        en = 1'b0;
        steps(1);
        chk_out("dis_stays_idle", 11'd0, 1'b1, 1'b0, 1'b0);
        en = 1'b1;
        period(1'b0, 1'b0);
        chk_out("dis_rerun", 11'd428, 1'b1, 1'b1, 1'b0);
        en = 1'b0;
        steps(1);
        chk_out("dis_midperiod", 11'd0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        spd_cmd       = '0;
        clr_fault     = 1'b0;
        pwm_synch     = 1'b0;
        ovr_i_blank_n = 1'b0;
        ovr_i         = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset;
        test_run;
        test_saturation;
        test_blanking;
        test_overcurrent;
        test_fault_clear;
        test_disable;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
